// File: rtl/bk_pkg.sv
// bk_pkg: constants and prefix-network geometry shared by the Brent-Kung
// adder and subtractor pipelines.
//   WIDTH    operand width (the network below is laid out for 16 bits only)
//   LATENCY  pipeline stages from input register to result register
// Stage numbering: S1 = operand P/G, S2..S5 = up-sweep, S6..S8 = down-sweep.
package bk_pkg;

    localparam int WIDTH   = 16;
    localparam int LATENCY = 8;

    // Span combined at each up-sweep level (S2..S5).
    localparam int UP_SPAN [0:3] = '{2, 4, 8, 16};
    // Span combined at each down-sweep level (S6..S8).
    localparam int DN_SPAN [0:2] = '{8, 4, 2};

    // Down-sweep node index tables: the carry position each node fills
    // and the node it takes its low-side group from.
    //   S6 : 11 <- 7
    //   S7 : 5 <- 3, 9 <- 7, 13 <- 11
    //   S8 : 2k <- 2k-1 for k = 1..7
    function automatic int stage_span(input int stage);
        if (stage <= 5) return UP_SPAN[stage - 2];
        else            return DN_SPAN[stage - 6];
    endfunction

    // The networks are in place: bit position i always holds the group
    // ending at bit i. Up-sweep nodes sit at the top of each span;
    // down-sweep nodes sit in the middle of a span above the first one.
    function automatic bit is_node(input int stage, input int i);
        int sp;
        sp = stage_span(stage);
        if (stage <= 5) return ((i + 1) % sp) == 0;
        else            return (((i + 1) % sp) == sp / 2) && (i >= sp);
    endfunction

    // Low-side source position for a node (same rule in both sweeps).
    function automatic int node_src(input int stage, input int i);
        return i - stage_span(stage) / 2;
    endfunction

endpackage

// File: rtl/bk_gp_cell.sv
// bk_gp_cell: Brent-Kung black cell, combines a high group (gh, ph) with
// the adjacent low group (gl, pl).
//   gh, ph  generate/propagate of the high group
//   gl, pl  generate/propagate of the low group
//   g, p    generate/propagate of the merged group
module bk_gp_cell (
    input  logic gh,
    input  logic ph,
    input  logic gl,
    input  logic pl,
    output logic g,
    output logic p
);

    assign g = gh | (ph & gl);
    assign p = ph & pl;

endmodule

// File: rtl/bk_subtractor.sv
// bk_subtractor: 8-stage pipelined Brent-Kung subtractor, D = A - B - Bin
// computed as A + ~B + ~Bin, with valid/ready handshakes and back-pressure.
//   clk, rst              clock, asynchronous active-high reset
//   in_valid / in_ready   operand handshake (in_ready is combinational)
//   A, B, Bin             minuend, subtrahend, borrow-in
//   out_valid / out_ready result handshake
//   Diff                  A - B - Bin mod 2^16
//   Bout, Ovf, Zero       borrow-out, signed overflow, Diff == 0
module bk_subtractor #(
    parameter int WIDTH = bk_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             Ovf,
    output logic             Zero
);

    import bk_pkg::*;

    if (WIDTH != 16) begin : g_bad_width
        $error("bk_subtractor: only WIDTH = 16 is supported");
    end

    logic [LATENCY:1] v_q;
    logic             stall;

    logic [15:0] g_q  [1:7];
    logic [15:0] p_q  [1:7];
    logic [15:0] p0_q [1:7];
    logic [7:1]  c0_q;

    logic [15:0] nxt_g [2:8];
    logic [15:0] nxt_p [2:8];

    logic [15:0] nb;
    logic [15:0] p0_in;
    logic [15:0] g0_in;
    logic [16:0] carry;
    logic [15:0] diff_d;
    logic        unused_p;

    assign out_valid = v_q[LATENCY];
    assign stall     = out_valid & ~out_ready;
    assign in_ready  = ~stall & ~rst;

    // Bit 0 generate absorbs the carry-in ~Bin so the prefix tree never
    // needs a separate carry-in node.
    always_comb begin
        nb       = ~B;
        p0_in    = A ^ nb;
        g0_in    = A & nb;
        g0_in[0] = (A[0] & nb[0]) | (~Bin & (A[0] | nb[0]));
    end

    for (genvar s = 2; s <= 8; s++) begin : g_stage
        for (genvar i = 0; i < 16; i++) begin : g_bit
            if (is_node(s, i)) begin : g_node
                bk_gp_cell u_cell (
                    .gh (g_q[s-1][i]),
                    .ph (p_q[s-1][i]),
                    .gl (g_q[s-1][node_src(s, i)]),
                    .pl (p_q[s-1][node_src(s, i)]),
                    .g  (nxt_g[s][i]),
                    .p  (nxt_p[s][i])
                );
            end else begin : g_pass
                assign nxt_g[s][i] = g_q[s-1][i];
                assign nxt_p[s][i] = p_q[s-1][i];
            end
        end
    end

    // After S8 every position i holds G[i:0], i.e. the carry into bit i+1.
    // Position 15 already holds C16 from S5 onward.
    assign carry    = {nxt_g[8], c0_q[7]};
    assign diff_d   = p0_q[7] ^ carry[15:0];
    // Group propagates are dead once the last sweep completes.
    assign unused_p = ^{nxt_p[8], p_q[7]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q  <= '0;
            c0_q <= '0;
            Diff <= '0;
            Bout <= 1'b0;
            Ovf  <= 1'b0;
            Zero <= 1'b0;
            for (int s = 1; s <= 7; s++) begin
                g_q[s]  <= '0;
                p_q[s]  <= '0;
                p0_q[s] <= '0;
            end
        end else if (!stall) begin
            v_q     <= {v_q[LATENCY-1:1], in_valid & in_ready};
            g_q[1]  <= g0_in;
            p_q[1]  <= p0_in;
            p0_q[1] <= p0_in;
            c0_q[1] <= ~Bin;
            for (int s = 2; s <= 7; s++) begin
                g_q[s]  <= nxt_g[s];
                p_q[s]  <= nxt_p[s];
                p0_q[s] <= p0_q[s-1];
                c0_q[s] <= c0_q[s-1];
            end
            Diff <= diff_d;
            Bout <= ~carry[16];
            Ovf  <= carry[16] ^ carry[15];
            Zero <= ~|diff_d;
        end
    end

endmodule

// File: tb/tb_bk_subtractor.sv
module tb_bk_subtractor;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic        Bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] Diff;
    logic        Bout;
    logic        Ovf;
    logic        Zero;

    typedef struct {
        logic [15:0] diff;
        logic        bout;
        logic        ovf;
        logic        zero;
        int          acc;
        bit          chk_lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    bk_subtractor #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Bin       (Bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Diff      (Diff),
        .Bout      (Bout),
        .Ovf       (Ovf),
        .Zero      (Zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic bin, input int acc, input bit lat);
        logic [16:0] full;
        exp_t        e;
        full      = {1'b0, a} - {1'b0, b} - {16'b0, bin};
        e.diff    = full[15:0];
        e.bout    = full[16];
        e.ovf     = (a[15] != b[15]) && (full[15] != a[15]);
        e.zero    = (full[15:0] == 16'h0);
        e.acc     = acc;
        e.chk_lat = lat;
        return e;
    endfunction

    // Result monitor: outputs are sampled mid-cycle; a beat with out_ready
    // high here is consumed on the following rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid) begin
            chk("out_has_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0 && out_ready) begin
                e = sb.pop_front();
                chk("diff", 32'(Diff), 32'(e.diff));
                chk("bout", 32'(Bout), 32'(e.bout));
                chk("ovf",  32'(Ovf),  32'(e.ovf));
                chk("zero", 32'(Zero), 32'(e.zero));
                if (e.chk_lat) chk("latency", 32'(cyc - e.acc), 32'd8);
            end
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b,
                        input logic bin, input bit lat);
        bit ok;
        ok       = 1'b0;
        A        = a;
        B        = b;
        Bin      = bin;
        in_valid = 1'b1;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(model(a, b, bin, cyc, lat));
                ok = 1'b1;
            end
        end
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge clk);
        chk("drain", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] d0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        A         = '0;
        B         = '0;
        Bin       = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_diff",      32'(Diff),      32'd0);
        chk("rst_flags",     32'({Bout, Ovf, Zero}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", 32'(in_ready), 32'd1);

        // Directed cases, back-to-back, each with its latency checked.
        send(16'h0005, 16'h0003, 1'b0, 1'b1);
        send(16'h0000, 16'h0001, 1'b0, 1'b1);
        send(16'h8000, 16'h0001, 1'b0, 1'b1);
        send(16'h7FFF, 16'hFFFF, 1'b0, 1'b1);
        send(16'h1234, 16'h1233, 1'b1, 1'b1);
        send(16'h0000, 16'h0000, 1'b1, 1'b1);
        send(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
        in_valid = 1'b0;
        wait_drain();

        // Back-pressure: 20 random beats with a 3-cycle stall mid-stream.
        for (int n = 0; n < 20; n++) begin
            if (n == 12) begin
                in_valid  = 1'b0;
                out_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk("stall_out_valid", 32'(out_valid), 32'd1);
                    chk("stall_in_ready",  32'(in_ready),  32'd0);
                    if (k == 0) d0 = Diff;
                    else        chk("stall_diff_hold", 32'(Diff), 32'(d0));
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
            send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        end
        in_valid = 1'b0;
        wait_drain();

        // Reset mid-flight: four beats in the pipe, short rst pulse.
        send(16'h1111, 16'h0101, 1'b0, 1'b0);
        send(16'h2222, 16'h3333, 1'b1, 1'b0);
        send(16'h4444, 16'h4444, 1'b0, 1'b0);
        send(16'h9999, 16'h0001, 1'b1, 1'b0);
        in_valid = 1'b0;
        #1;
        rst = 1'b1;
        sb.delete();
        #1;
        chk("pulse_out_valid", 32'(out_valid), 32'd0);
        chk("pulse_in_ready",  32'(in_ready),  32'd0);
        chk("pulse_diff",      32'(Diff),      32'd0);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("post_rst_idle", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        send(16'hABCD, 16'h1234, 1'b1, 1'b1);
        in_valid = 1'b0;
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
